// File: rtl/muldiv_sequencer.sv
// Iterative HI/LO multiply/divide unit: shift-add multiply, restoring divide, MFHI/MFLO/MTHI/MTLO.
// Define MULDIV_EARLY_OUT_EN to end multiplies early and to short-circuit divide by zero.
module muldiv_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             w_clock,
  input  logic             w_reset_n,
  input  logic             w_valid_1,
  input  logic [5:0]       w_funct_6,
  input  logic [WIDTH-1:0] w_input1_x,
  input  logic [WIDTH-1:0] w_input2_x,
  output logic [WIDTH-1:0] w_output_x,
  output logic             w_busy_1,
  output logic             w_stall_1,
  output logic             w_done_1
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FIXUP = 2'd2;

  localparam logic [5:0] F_MFHI = 6'h10;
  localparam logic [5:0] F_MTHI = 6'h11;
  localparam logic [5:0] F_MFLO = 6'h12;
  localparam logic [5:0] F_MTLO = 6'h13;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic             div_q, div_d;
  logic             neg_res_q, neg_res_d;
  logic             neg_rem_q, neg_rem_d;
  logic             dz_q, dz_d;
  logic             done_q, done_d;

  logic             is_md, is_hilo, is_div_op, signed_op, early_exit;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   sum, rem_sh, diff;
  logic [2*WIDTH-1:0] prod;

  // MULT/MULTU/DIV/DIVU are 0x18..0x1B; the HI/LO moves are 0x10..0x13.
  assign is_md     = (w_funct_6[5:2] == 4'b0110);
  assign is_hilo   = (w_funct_6[5:2] == 4'b0100);
  assign is_div_op = w_funct_6[1];
  assign signed_op = ~w_funct_6[0];
  assign mag_a     = (signed_op && w_input1_x[WIDTH-1]) ? -w_input1_x : w_input1_x;
  assign mag_b     = (signed_op && w_input2_x[WIDTH-1]) ? -w_input2_x : w_input2_x;

  assign w_busy_1  = (state_q != S_IDLE);
  assign w_stall_1 = w_busy_1 & w_valid_1 & (is_md | is_hilo);
  assign w_done_1  = done_q;

  always_comb begin
    w_output_x = '0;
    if (w_valid_1 && state_q == S_IDLE) begin
      if (w_funct_6 == F_MFHI) w_output_x = hi_q;
      else if (w_funct_6 == F_MFLO) w_output_x = lo_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    div_d      = div_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    dz_d       = dz_q;
    done_d     = 1'b0;
    sum        = '0;
    rem_sh     = '0;
    diff       = '0;
    prod       = '0;
    early_exit = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (w_valid_1 && is_md) begin
          state_d   = S_RUN;
          cnt_d     = '0;
          acc_d     = '0;
          mcand_d   = is_div_op ? mag_b : mag_a;
          mplier_d  = is_div_op ? mag_a : mag_b;
          div_d     = is_div_op;
          neg_res_d = signed_op & (w_input1_x[WIDTH-1] ^ w_input2_x[WIDTH-1]);
          neg_rem_d = signed_op & w_input1_x[WIDTH-1];
          dz_d      = is_div_op && (w_input2_x == '0);
`ifdef MULDIV_EARLY_OUT_EN
          if (is_div_op && w_input2_x == '0) begin
            state_d = S_FIXUP;
            acc_d   = mag_a;
          end
`endif
        end else if (w_valid_1 && w_funct_6 == F_MTHI) begin
          hi_d = w_input1_x;
        end else if (w_valid_1 && w_funct_6 == F_MTLO) begin
          lo_d = w_input1_x;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + CNT_ONE;
        if (div_q) begin
          // The quotient register shifts its top bit into the partial remainder.
          rem_sh   = {acc_q, mplier_q[WIDTH-1]};
          diff     = rem_sh - {1'b0, mcand_q};
          acc_d    = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
          mplier_d = {mplier_q[WIDTH-2:0], ~diff[WIDTH]};
        end else begin
          sum      = {1'b0, acc_q} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
          acc_d    = sum[WIDTH:1];
          mplier_d = {sum[0], mplier_q[WIDTH-1:1]};
        end
`ifdef MULDIV_EARLY_OUT_EN
        // Unconsumed multiplier bits sit in the low WIDTH-cnt_d bits of mplier_d.
        early_exit = !div_q && ((mplier_d & (ALL_ONES >> cnt_d)) == '0);
`endif
        if (early_exit || cnt_q == CNT_LAST) state_d = S_FIXUP;
      end
      S_FIXUP: begin
        if (div_q) begin
          lo_d = dz_q ? ALL_ONES : (neg_res_q ? -mplier_q : mplier_q);
          hi_d = neg_rem_q ? -acc_q : acc_q;
        end else begin
          // Realign by the iterations skipped; zero when all WIDTH ran.
          prod = {acc_q, mplier_q} >> (CNT_FULL - cnt_q);
          if (neg_res_q) prod = -prod;
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge w_clock) begin
    if (!w_reset_n) begin
      state_q   <= S_IDLE;
      hi_q      <= '0;
      lo_q      <= '0;
      cnt_q     <= '0;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      div_q     <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      div_q     <= div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle multiply/divide engine that owns the architectural HI/LO registers for the MIPS core.
- Executes MULT, MULTU, DIV and DIVU iteratively: shift-add for multiply, restoring division for divide.
- Services MFHI, MFLO, MTHI and MTLO.
- Sits beside the single-cycle ALU in the execute stage and raises a stall toward the pipeline while an operation is in flight.

Parameters:
- WIDTH, 32, operand/HI/LO width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- w_clock  input  1  rising-edge clock.
- w_reset_n  input  1  synchronous active-low reset.
- w_valid_1  input  1  execute stage presents a mul/div/HI-LO instruction this cycle.
- w_funct_6  input  6  SPECIAL funct: MFHI 0x10, MTHI 0x11, MFLO 0x12, MTLO 0x13, MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B.
- w_input1_x  input  WIDTH  rs value (multiplicand/dividend; MTHI/MTLO data).
- w_input2_x  input  WIDTH  rt value (multiplier/divisor).
- w_output_x  output  WIDTH  MFHI/MFLO result; combinational.
- w_busy_1  output  1  operation in flight.
- w_stall_1  output  1  pipeline must hold the current instruction; combinational.
- w_done_1  output  1  one-cycle pulse when HI/LO are updated by mult/div.

Behaviour:
- Clock and reset: single clock w_clock; reset w_reset_n is synchronous, active-low.
- Reset values: state IDLE, HI=0, LO=0, counter=0, w_busy_1=0, w_done_1=0.
- Reset mid-operation abandons the operation with no HI/LO write.
- States: IDLE, RUN, FIXUP.
- IDLE:
  - Accepts when w_valid_1 and the funct is a mult/div code.
  - Latches magnitudes: absolute values for signed ops, raw values for unsigned.
  - Latches the result sign and the dividend sign; clears the accumulator; counter=0; goes to RUN.
- RUN:
  - One iteration per cycle; counter increments.
  - Multiply: if multiplier LSB is set, accumulator += multiplicand; then shift the {acc, multiplier} pair right by one.
  - Divide: shift {rem, quot} left by one; trial subtract the divisor; if non-negative, keep the difference and set quot LSB.
  - After iteration WIDTH-1 (counter==WIDTH-1), go to FIXUP.
- FIXUP:
  - Applies two's-complement negation per the latched signs.
  - Writes HI/LO, returns to IDLE and pulses w_done_1 in the following cycle.
- Latency: accept edge E0, iterations E1..E32, HI/LO written at E33. w_busy_1 is high for the 33 cycles after E0 and drops in the same cycle w_done_1 rises.
- Results:
  - MULT/MULTU: {HI,LO} = 64-bit product.
  - DIV/DIVU: LO = quotient, HI = remainder. Signed quotient truncates toward zero; remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF (signed): LO=0x80000000, HI=0.
  - Divide by zero: LO=0xFFFFFFFF, HI=dividend as presented, signed or not. Full latency still applies unless the optional feature is enabled.
- MTHI/MTLO: when idle, write HI/LO at the next edge; no busy, no done.
- MFHI/MFLO:
  - When idle, w_output_x = HI/LO combinationally.
  - w_output_x = 0 for any other funct or when w_valid_1 is low.
- Stall:
  - w_stall_1 = w_busy_1 & w_valid_1 (any of the eight functs), so all HI/LO hazards stall.
  - The instruction presented during busy is not executed.
  - It is accepted on the first idle cycle, which is the same cycle w_done_1 is high. Back-to-back operations therefore have no bubble beyond the stall.
- Unrecognised funct with w_valid_1 is ignored: no state change, no stall.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- Defined:
  - Multiply leaves RUN as soon as the remaining multiplier bits are all zero, after at least one iteration. It finishes with the accumulator and low half realigned by the remaining shift count.
  - Divide by zero goes IDLE→FIXUP directly, giving a 2-cycle latency.
  - Results must be bit-identical to the undefined build.
- Undefined: fixed 33-cycle latency for every mult/div.

Test Plan:
- Reset, then MULTU 0xFFFFFFFF*0xFFFFFFFF → after 33 busy cycles, done pulse; MFHI=0xFFFFFFFE, MFLO=0x00000001.
- MULT 0xFFFFFFFD(-3)*7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB. DIV -7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 100/0 → LO=0xFFFFFFFF, HI=100. DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- Issue MFLO on cycle 5 of a DIVU 10/3 → w_stall_1 high until done; MFLO then returns 3. MFHI returns 1.
- MTHI 0x1234 and MTLO 0x5678 while idle → MFHI/MFLO return them next cycle with no stall. Drop w_reset_n on cycle 10 of a MULT → HI=LO=0, busy=0, no done pulse.
- With MULDIV_EARLY_OUT_EN: MULTU 0x12345678*3 → done within 3 cycles of accept, LO=0x369D0368, HI=0. DIVU 5/0 → done 2 cycles after accept.
